truth_table_capture: RTL and testbench
======================================

Name: truth_table_capture

Overview:
- Characterisation block: drives every input combination onto a combinational logic cell under test and samples its output.
- Rebuilds the cell's hex truth-table code; this is the reverse of a truth-table-to-gate mapping.
- Sits on the test harness between a start/done controller and the cell's inputs and output.
- Captured code uses the library's ordering: input 000 maps to the MSB.

Parameters:
- N_IN, 3, number of cell inputs; table width TT_W = 2**N_IN.
- SETTLE_CYCLES, 4, cycles each combination is held before sampling begins; must be ≥1.
- SAMPLE_COUNT, 3, samples per combination, resolved by majority vote; must be odd and ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request a capture run; accepted only in IDLE.
- abort  input  1  cancel the run in progress.
- expected  input  TT_W  reference code for comparison.
- dut_out  input  1  output of the cell under test.
- dut_in  output  N_IN  input combination driven to the cell; dut_in[N_IN-1] is in1.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when a run completes.
- truth_table  output  TT_W  last completed code.
- match  output  1  truth_table == expected; valid whenever done is high.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: reset_n sampled low at a rising clk edge resets the block.
- Reset values: state IDLE; dut_in=0; busy=0; done=0; truth_table=0; match=0; all counters=0.
- States:
  - IDLE: dut_in=0. If start=1 and abort=0 → SETTLE with index=0 and shadow=0.
  - SETTLE: dut_in=index. After SETTLE_CYCLES cycles → SAMPLE.
  - SAMPLE: dut_in=index. Sample dut_out at each of SAMPLE_COUNT edges and count ones. On the last sample, compute bit = (ones*2 > SAMPLE_COUNT) and write it to shadow[TT_W-1-index].
    - If index == TT_W-1 → DONE.
    - Otherwise index+1 → SETTLE, with counters cleared.
  - DONE: one cycle. truth_table←shadow (including the final bit); done=1; match=(shadow==expected); busy=0; → IDLE.
- busy=1 in SETTLE and SAMPLE only. It stays high for exactly TT_W*(SETTLE_CYCLES+SAMPLE_COUNT) cycles, which is 56 with defaults.
- done follows the last busy cycle immediately. busy and done are never high together.
- truth_table and match change only in DONE and hold until the next DONE or reset.
- Abort: abort=1 in SETTLE or SAMPLE → IDLE on the next edge. No done pulse; shadow is discarded; truth_table and match are unchanged.
- Abort in IDLE or DONE has no effect. If start=1 and abort=1 in IDLE, abort wins and the block stays IDLE.
- start while busy or in DONE is ignored and not queued.
- Reset mid-run takes priority over everything: all registers return to reset values, including truth_table.
- Index is N_IN bits wide and stops at TT_W-1; it never wraps within a run.
- The ones counter is sized $clog2(SAMPLE_COUNT+1) bits and saturates; it cannot overflow.

Decomposition:
- Package truth_table_capture_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - a localparam function tt_width(n) = 2**n;
  - a majority(ones, count) function.
- One sub-module, phase_timer: a loadable down-counter with terminal-count flag, used for both the settle and sample phases.

Test Plan:
- Combinational cell model for code 0x76 (000→0, 001→1, 010→1, 011→1, 100→0, 101→1, 110→1, 111→0), expected=0x76, start for one cycle → busy for 56 cycles, then done for 1 cycle, truth_table=0x76, match=1; dut_in steps 0..7, each held 7 cycles.
- Same cell with expected=0x6E → truth_table=0x76, match=0.
- Cell model with 2-cycle output delay, plus dut_out forced wrong on one of three samples for combination 011 → truth_table still 0x76.
- abort asserted on busy cycle 20 after a prior completed 0x76 run (cell swapped to constant 1) → IDLE next cycle, no done, truth_table stays 0x76; a following start gives 0xFF.
- start pulsed again mid-run → ignored; exactly one done pulse at cycle 57.
- reset_n low for 1 cycle mid-run → next cycle busy=0, done=0, dut_in=0, truth_table=0x00; a new start then completes normally.

Source files
------------

// File: rtl/truth_table_capture_pkg.sv
// Shared types and helpers for the truth-table capture block.
//   state_t    : capture FSM states
//   tt_width   : truth-table width for an n-input cell (2**n)
//   majority   : majority-vote decision over a number of samples
package truth_table_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

    // A bit is 1 when strictly more than half of the samples were 1.
    function automatic logic majority(input int ones, input int count);
        return (ones * 2) > count;
    endfunction

endpackage

// File: rtl/truth_table_capture_phase_timer.sv
// Loadable down-counter used to time both the settle and sample phases.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : load load_value on the next edge
//   load_value   : phase length minus one
//   tc           : terminal count, high while the counter is zero
module phase_timer
    import truth_table_capture_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Loading N-1 makes the phase last exactly N cycles, tc on the last.
    assign tc = (count == '0);

endmodule

// File: rtl/truth_table_capture.sv
// Truth-table capture: walks a combinational cell through every input
// combination, majority-votes its output, and rebuilds the hex code with
// input 0 in the MSB.
//   clk, reset_n : clock, synchronous active-low reset
//   start, abort : run request (IDLE only) / cancel a run in progress
//   expected     : reference code compared when a run completes
//   dut_out      : cell output
//   dut_in       : combination driven to the cell
//   busy, done   : run in progress / one-cycle completion pulse
//   truth_table  : last completed code; match : truth_table == expected
module truth_table_capture
    import truth_table_capture_pkg::*;
#(
    parameter  int N_IN          = 3,
    parameter  int SETTLE_CYCLES = 4,   // >= 1
    parameter  int SAMPLE_COUNT  = 3,   // odd, >= 1
    localparam int TT_W          = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] truth_table,
    output logic            match
);

    localparam int ONES_W    = $clog2(SAMPLE_COUNT + 1);
    localparam int MAX_PHASE = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int TMR_W     = $clog2(MAX_PHASE + 1);

    localparam logic [N_IN-1:0]   LAST_INDEX  = N_IN'(TT_W - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SAMPLE_LOAD = TMR_W'(SAMPLE_COUNT - 1);
    localparam logic [ONES_W-1:0] ONES_MAX    = ONES_W'(SAMPLE_COUNT);

    state_t            state, state_next;
    logic [N_IN-1:0]   index;
    logic [ONES_W-1:0] ones;
    logic [TT_W-1:0]   shadow, shadow_final;
    logic [N_IN-1:0]   bit_pos;
    logic              sample_bit;
    logic              phase_done;
    logic              timer_load;
    logic [TMR_W-1:0]  timer_value;

    phase_timer #(.WIDTH(TMR_W)) u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (phase_done)
    );

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = SETTLE_LOAD;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (phase_done) begin
                    state_next  = SAMPLE;
                    timer_load  = 1'b1;
                    timer_value = SAMPLE_LOAD;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (phase_done) begin
                    if (index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        state_next = SETTLE;
                        timer_load = 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The last sample is still on dut_out, so it joins the vote directly
    // instead of going through the ones counter first.
    assign sample_bit = majority(int'(ones) + int'(dut_out), SAMPLE_COUNT);
    assign bit_pos    = LAST_INDEX - index;

    always_comb begin
        shadow_final          = shadow;
        shadow_final[bit_pos] = sample_bit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // truth_table/match load on the edge into DONE so they are already
    // valid during the done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index       <= '0;
            ones        <= '0;
            shadow      <= '0;
            truth_table <= '0;
            match       <= 1'b0;
        end else begin
            if (state == IDLE && state_next == SETTLE) begin
                index  <= '0;
                shadow <= '0;
            end
            if (state != SAMPLE || abort) begin
                ones <= '0;
            end else if (phase_done) begin
                ones   <= '0;
                shadow <= shadow_final;
                if (index == LAST_INDEX) begin
                    truth_table <= shadow_final;
                    match       <= (shadow_final == expected);
                end else begin
                    index <= index + 1'b1;
                end
            end else if (ones != ONES_MAX) begin
                ones <= ones + ONES_W'(dut_out);
            end
        end
    end

    assign busy   = (state == SETTLE) || (state == SAMPLE);
    assign done   = (state == DONE);
    assign dut_in = busy ? index : '0;

endmodule

// File: tb/tb_truth_table_capture.sv
module tb_truth_table_capture;

    localparam int N_IN      = 3;
    localparam int TT_W      = 8;
    localparam int HOLD      = 4 + 3;          // settle + samples per combination
    localparam int BUSY_LEN  = TT_W * HOLD;    // 56
    localparam int RUN_SPAN  = 70;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [TT_W-1:0] expected = '0;
    logic            dut_out;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] truth_table;
    logic            match;

    int checks = 0;
    int errors = 0;

    // Cell model: lookup table, optional 2-cycle output delay, and a
    // single-cycle output flip at busy cycle glitch_cycle.
    logic            tbl [0:TT_W-1];
    bit              delay_mode = 1'b0;
    int              cyc_k = -100;
    int              glitch_cycle = -1;
    logic [N_IN-1:0] in_d1, in_d2, src;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        in_d1 <= dut_in;
        in_d2 <= in_d1;
    end

    assign src     = delay_mode ? in_d2 : dut_in;
    assign dut_out = tbl[src] ^ (cyc_k == glitch_cycle);

    truth_table_capture dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .expected    (expected),
        .dut_out     (dut_out),
        .dut_in      (dut_in),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table),
        .match       (match)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: pack the cell's table with input 0 landing in the MSB.
    function automatic logic [TT_W-1:0] ref_code();
        logic [TT_W-1:0] code = '0;
        for (int i = 0; i < TT_W; i++) code = {code[TT_W-2:0], tbl[i]};
        return code;
    endfunction

    task automatic load_table(input logic [TT_W-1:0] code);
        for (int i = 0; i < TT_W; i++) tbl[i] = code[TT_W-1-i];
    endtask

    // One capture run. abort_at/restart_at are busy-cycle numbers (0 = none).
    task automatic run(input string tag, input logic [TT_W-1:0] exp_in,
                       input int abort_at, input int restart_at,
                       input logic [TT_W-1:0] want_tt, input logic want_match);
        int   busy_cycles = 0;
        int   done_cycles = 0;
        int   done_at = -1;
        bit   seq_ok = 1'b1;
        logic [TT_W-1:0] tt_at_done = '0;
        logic match_at_done = 1'b0;
        expected = exp_in;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= RUN_SPAN; k++) begin
            cyc_k = k;
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                done_at       = k;
                tt_at_done    = truth_table;
                match_at_done = match;
            end
            if (busy && done) seq_ok = 1'b0;
            if (busy && dut_in !== 3'((k - 1) / HOLD)) seq_ok = 1'b0;
            if (!busy && dut_in !== 3'd0) seq_ok = 1'b0;
            abort = (k == abort_at);
            start = (k == restart_at);
            @(posedge clk); #1;
        end
        cyc_k = -100;
        abort = 1'b0;
        start = 1'b0;
        check({tag, " busy_len"}, busy_cycles, (abort_at != 0) ? abort_at : BUSY_LEN);
        check({tag, " done_cnt"}, done_cycles, (abort_at != 0) ? 0 : 1);
        check({tag, " done_at"}, done_at, (abort_at != 0) ? -1 : BUSY_LEN + 1);
        check({tag, " sequence"}, {31'd0, seq_ok}, 32'd1);
        if (done_at > 0) begin
            check({tag, " tt_at_done"}, tt_at_done, want_tt);
            check({tag, " match_at_done"}, match_at_done, want_match);
        end
        check({tag, " tt_hold"}, truth_table, want_tt);
        check({tag, " match_hold"}, match, want_match);
    endtask

    initial begin
        logic [TT_W-1:0] r_code;
        logic [TT_W-1:0] r_exp;
        load_table(8'h76);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dut_in", dut_in, 0);
        check("reset tt", truth_table, 0);
        check("reset match", match, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic capture, matching and mismatching reference.
        run("tt76", 8'h76, 0, 0, 8'h76, 1'b1);
        run("tt76_vs_6e", 8'h6E, 0, 0, 8'h76, 1'b0);

        // Delayed cell plus one wrong sample on combination 011.
        delay_mode   = 1'b1;
        glitch_cycle = 3 * HOLD + 6;
        run("delay_glitch", 8'h76, 0, 0, 8'h76, 1'b1);
        delay_mode   = 1'b0;
        glitch_cycle = -1;

        // Abort mid-run with a constant-1 cell; previous result must hold.
        load_table(8'hFF);
        run("abort", 8'hFF, 20, 0, 8'h76, 1'b1);
        run("const1", 8'hFF, 0, 0, 8'hFF, 1'b1);

        // start+abort together in IDLE: abort wins; lone abort in IDLE is inert.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_abort idle busy", busy, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle abort tt", truth_table, 8'hFF);

        // A second start mid-run is ignored.
        load_table(8'h76);
        run("restart_ignored", 8'h76, 0, 30, 8'h76, 1'b1);

        // Synchronous reset mid-run.
        load_table(8'h3C);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (24) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset dut_in", dut_in, 0);
        check("midreset tt", truth_table, 8'h00);
        check("midreset match", match, 0);
        @(posedge clk); #1;
        run("after_reset", 8'h3C, 0, 0, 8'h3C, 1'b1);

        // Random cells, random reference, one random bad sample per run.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < TT_W; i++) tbl[i] = 1'($urandom_range(0, 1));
            r_code = ref_code();
            r_exp  = ($urandom_range(0, 1) == 0) ? r_code : r_code ^ 8'(1 << $urandom_range(0, 7));
            glitch_cycle = HOLD * $urandom_range(0, TT_W - 1) + 5 + $urandom_range(0, 2);
            run($sformatf("rand%0d", r), r_exp, 0, 0, r_code, r_exp == r_code);
        end
        glitch_cycle = -1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
